// File: rtl/reg_alu_core.sv
// Register-file ALU core: an 8-entry (by default) register bank with R0 as
// accumulator. Loads write a register directly. Executes run either a
// single-cycle ALU op or a WIDTH-iteration shift-add multiply.
module reg_alu_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     regs [DEPTH];
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic [3:0]           op_reg;
  logic                 cin_reg;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic [WIDTH:0]       mul_sum;
  logic [CW-1:0]        cnt_reg;
  logic                 cnt_last;
  logic                 carry_reg, zero_reg, done_reg;
  logic                 accept, alu_commit, mul_commit, finish;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH:0]       alu_sum;
  logic                 alu_carry, alu_wr;
  logic [DEPTH-1:0]     load_hit, reg_we;
  logic [WIDTH-1:0]     reg_wd [DEPTH];

  assign accept   = cmd_valid && cmd_ready;
  assign cnt_last = (cnt_reg == CW'(WIDTH - 1));
  assign data_out = regs[0];
  assign carry    = carry_reg;
  assign zero     = zero_reg;
  assign done     = done_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: loads never leave IDLE; MUL runs until the last iteration
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid && !cmd_load) state_next = EXEC;
      EXEC:    state_next = (op_reg == 4'd8) ? MUL : IDLE;
      MUL:     if (cnt_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/strobe decode from the current state
  always_comb begin
    cmd_ready  = 1'b0;
    alu_commit = 1'b0;
    mul_commit = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: cmd_ready = 1'b1;
      EXEC: if (op_reg != 4'd8) begin
        finish     = 1'b1;
        alu_commit = alu_wr;
      end
      MUL: if (cnt_last) begin
        finish     = 1'b1;
        mul_commit = 1'b1;
      end
      default: ;
    endcase
  end

  // Single-cycle ALU on the operands latched at accept; reserved ops write nothing
  always_comb begin
    alu_res   = '0;
    alu_sum   = '0;
    alu_carry = 1'b0;
    alu_wr    = 1'b1;
    case (op_reg)
      4'd0: begin
        alu_sum   = {1'b0, a_reg} + {1'b0, b_reg};
        alu_res   = alu_sum[WIDTH-1:0];
        alu_carry = alu_sum[WIDTH];
      end
      4'd1: begin
        alu_sum   = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, cin_reg};
        alu_res   = alu_sum[WIDTH-1:0];
        alu_carry = alu_sum[WIDTH];
      end
      4'd2: begin
        alu_res   = a_reg - b_reg;
        alu_carry = (a_reg < b_reg);
      end
      4'd3:    alu_res = a_reg & b_reg;
      4'd4:    alu_res = a_reg | b_reg;
      4'd5:    alu_res = a_reg ^ b_reg;
      4'd6:    alu_res = b_reg;
      4'd7:    alu_res = ~a_reg;
      default: alu_wr  = 1'b0;
    endcase
  end

  // One shift-add step: add A into the high half if the current multiplier bit is set, shift right
  always_comb begin
    mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, a_reg & {WIDTH{prod_reg[0]}}};
    prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
  end

  // Operand latch and multiply datapath; B is captured so a MUL on R1 is unaffected by its own write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      cin_reg  <= 1'b0;
      prod_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (accept && !cmd_load) begin
        a_reg   <= regs[0];
        b_reg   <= regs[cmd_addr];
        op_reg  <= cmd_op;
        cin_reg <= cin;
      end
      if (state_reg == EXEC) begin
        prod_reg <= {{WIDTH{1'b0}}, b_reg};
        cnt_reg  <= '0;
      end else if (state_reg == MUL) begin
        prod_reg <= prod_next;
        cnt_reg  <= cnt_reg + CW'(1);
      end
    end
  end

  // Flags and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= finish;
      if (alu_commit) begin
        carry_reg <= alu_carry;
        zero_reg  <= (alu_res == '0);
      end else if (mul_commit) begin
        carry_reg <= |prod_next[2*WIDTH-1:WIDTH];
        zero_reg  <= (prod_next == '0);
      end
    end
  end

  // Per-register write port select: loads happen only in IDLE, commits only outside it
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
    assign load_hit[gi] = accept && cmd_load && (cmd_addr == AW'(gi));
    if (gi == 0) begin : g_r0
      assign reg_we[gi] = load_hit[gi] | alu_commit | mul_commit;
      assign reg_wd[gi] = alu_commit ? alu_res :
                          mul_commit ? prod_next[WIDTH-1:0] : data_in;
    end else if (gi == 1) begin : g_r1
      assign reg_we[gi] = load_hit[gi] | mul_commit;
      assign reg_wd[gi] = mul_commit ? prod_next[2*WIDTH-1:WIDTH] : data_in;
    end else begin : g_rn
      assign reg_we[gi] = load_hit[gi];
      assign reg_wd[gi] = data_in;
    end
  end

  // Register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (reg_we[i]) regs[i] <= reg_wd[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_alu_core.sv
// Bench for reg_alu_core: two instances (8-bit/8 regs and 16-bit/4 regs)
// driven in turn, checked against an arithmetic model of the register bank.
module tb_reg_alu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid8 = 1'b0, valid16 = 1'b0;
  logic        cmd_load = 1'b0, cin = 1'b0;
  logic [2:0]  cmd_addr = '0;
  logic [3:0]  cmd_op = '0;
  logic [15:0] data_in = '0;

  logic        ready8, carry8, zero8, done8;
  logic [7:0]  dout8;
  logic        ready16, carry16, zero16, done16;
  logic [15:0] dout16;

  logic        sel16 = 1'b0;
  logic        o_ready, o_carry, o_zero, o_done;
  logic [15:0] o_dout;

  int vectors = 0;
  int miscompares = 0;

  longint unsigned m_reg [2][16];
  bit              m_carry [2];
  bit              m_zero  [2];

  always #5 clk = ~clk;

  reg_alu_core #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .cmd_valid(valid8), .cmd_ready(ready8),
    .cmd_load(cmd_load), .cmd_addr(cmd_addr), .cmd_op(cmd_op),
    .data_in(data_in[7:0]), .cin(cin), .data_out(dout8),
    .carry(carry8), .zero(zero8), .done(done8)
  );

  reg_alu_core #(.WIDTH(16), .DEPTH(4)) u_dut16 (
    .clk(clk), .rst(rst), .cmd_valid(valid16), .cmd_ready(ready16),
    .cmd_load(cmd_load), .cmd_addr(cmd_addr[1:0]), .cmd_op(cmd_op),
    .data_in(data_in), .cin(cin), .data_out(dout16),
    .carry(carry16), .zero(zero16), .done(done16)
  );

  assign o_ready = sel16 ? ready16 : ready8;
  assign o_carry = sel16 ? carry16 : carry8;
  assign o_zero  = sel16 ? zero16  : zero8;
  assign o_done  = sel16 ? done16  : done8;
  assign o_dout  = sel16 ? dout16  : {8'h00, dout8};

  function automatic int cur();
    return sel16 ? 1 : 0;
  endfunction

  function automatic int width_of();
    return sel16 ? 16 : 8;
  endfunction

  function automatic int depth_of();
    return sel16 ? 4 : 8;
  endfunction

  function automatic longint unsigned mask_of();
    return (64'd1 << width_of()) - 64'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (w%0d): observed %0h expected %0h", tag, width_of(), obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 16; r++) m_reg[s][r] = 0;
      m_carry[s] = 1'b0;
      m_zero[s]  = 1'b0;
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel16) valid16 = v;
    else       valid8  = v;
  endtask

  task automatic do_load(input int addr, input longint unsigned data);
    int s;
    longint unsigned d;
    s = cur();
    d = data & mask_of();
    @(negedge clk);
    check("ready_before_load", o_ready, 1);
    cmd_load = 1'b1;
    cmd_addr = 3'(addr);
    data_in  = 16'(d);
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
    cmd_load = 1'b0;
    m_reg[s][addr] = d;
    check("load_dout", o_dout, m_reg[s][0]);
    check("load_no_done", o_done, 0);
    $display("[w%0d] load R%0d = %0h", width_of(), addr, d);
  endtask

  // Issue an execute; optionally hold a load to R1 pending while the core is busy
  task automatic exec_op(input int op, input int addr, input bit c,
                         input bit hold, input longint unsigned hold_data);
    int s, w, lat, exp_lat;
    bit seen, wr, car;
    longint unsigned a, b, t, res, hi, p, mask;
    s = cur();
    w = width_of();
    mask = mask_of();
    a = m_reg[s][0];
    b = m_reg[s][addr];
    wr = 1'b1; car = 1'b0; res = 0; hi = 0; p = 0;
    case (op)
      0: begin t = a + b;     res = t & mask; car = ((t >> w) & 1) != 0; end
      1: begin t = a + b + c; res = t & mask; car = ((t >> w) & 1) != 0; end
      2: begin res = (a - b) & mask; car = (a < b); end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = b;
      7: res = (~a) & mask;
      8: begin p = a * b; res = p & mask; hi = p >> w; car = (hi != 0); end
      default: wr = 1'b0;
    endcase
    exp_lat = (op == 8) ? w + 2 : 2;

    @(negedge clk);
    check("ready_before_exec", o_ready, 1);
    cmd_load = 1'b0;
    cmd_addr = 3'(addr);
    cmd_op   = 4'(op);
    cin      = c;
    set_valid(1'b1);
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_load = 1'b1;
      cmd_addr = 3'd1;
      data_in  = 16'(hold_data & mask);
    end else begin
      set_valid(1'b0);
    end

    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (o_done) seen = 1'b1;
    end

    if (wr) begin
      m_reg[s][0] = res;
      if (op == 8) m_reg[s][1] = hi;
      m_carry[s] = car;
      m_zero[s]  = (op == 8) ? (p == 0) : (res == 0);
    end
    check("done_seen", seen, 1);
    check("latency", lat, exp_lat);
    check("result_dout", o_dout, m_reg[s][0]);
    check("carry", o_carry, m_carry[s]);
    check("zero", o_zero, m_zero[s]);
    check("ready_at_done", o_ready, 1);
    $display("[w%0d] op=%0d a=%0h b=R%0d(%0h) cin=%0d -> data_out=%0h carry=%0b zero=%0b edges=%0d",
             w, op, a, addr, b, c, o_dout, o_carry, o_zero, lat);

    @(posedge clk);
    #1;
    if (hold) begin
      set_valid(1'b0);
      cmd_load = 1'b0;
      m_reg[s][1] = hold_data & mask;
    end
    check("done_one_cycle", o_done, 0);
  endtask

  // Start a MUL and hit reset in the middle of it
  task automatic mul_abort(input int addr);
    int w;
    w = width_of();
    @(negedge clk);
    cmd_load = 1'b0;
    cmd_addr = 3'(addr);
    cmd_op   = 4'd8;
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("abort_dout", o_dout, 0);
    check("abort_carry", o_carry, 0);
    check("abort_zero", o_zero, 0);
    check("abort_done", o_done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < w + 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", o_done, 0);
    end
    check("abort_ready", o_ready, 1);
    check("abort_dout_after", o_dout, 0);
    $display("[w%0d] reset during MUL", w);
  endtask

  task automatic run_suite();
    bit wide;
    longint unsigned mask, half;
    int big_addr;
    wide = sel16;
    mask = mask_of();
    half = 64'd1 << (width_of() - 1);
    big_addr = wide ? 3 : 5;

    // ADD with carry-out
    do_load(0, wide ? 64'hF000 : 64'hF0);
    do_load(3, wide ? 64'h2000 : 64'h20);
    exec_op(0, 3, 1'b0, 1'b0, 0);
    // SUB with borrow, then SUB to zero
    do_load(0, 5);
    do_load(2, 7);
    exec_op(2, 2, 1'b0, 1'b0, 0);
    do_load(2, mask - 1);
    exec_op(2, 2, 1'b0, 1'b0, 0);
    // MUL all-ones, then read R1 back via MOV
    do_load(0, mask);
    do_load(big_addr, mask);
    exec_op(8, big_addr, 1'b0, 1'b0, 0);
    exec_op(6, 1, 1'b0, 1'b0, 0);
    // MUL on R1, which is overwritten at completion
    do_load(1, 3);
    do_load(0, 7);
    exec_op(8, 1, 1'b0, 1'b0, 0);
    // B = R0
    exec_op(0, 0, 1'b0, 1'b0, 0);
    exec_op(1, 0, 1'b1, 1'b0, 0);
    // Load to R1 held during a MUL must land after the MUL write-back
    do_load(0, 9);
    exec_op(8, 0, 1'b0, 1'b1, 64'h5A);
    exec_op(6, 1, 1'b0, 1'b0, 0);
    // Reset mid-MUL, then a reserved op after reset
    mul_abort(big_addr);
    exec_op(12, 0, 1'b0, 1'b0, 0);
    // Reserved ops preserve set flags
    do_load(0, half);
    exec_op(0, 0, 1'b0, 1'b0, 0);
    exec_op(12, 2, 1'b1, 1'b0, 0);
    exec_op(15, 1, 1'b0, 1'b0, 0);
    exec_op(9, 0, 1'b0, 1'b0, 0);

    // Random mix of loads and executes
    for (int n = 0; n < 40; n++) begin
      int addr;
      addr = $urandom_range(0, depth_of() - 1);
      if ($urandom_range(0, 3) == 0)
        do_load(addr, longint'($urandom()));
      else
        exec_op($urandom_range(0, 15), addr, 1'($urandom_range(0, 1)), 1'b0, 0);
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel16 = 1'(s);
      #1;
      check("reset_dout", o_dout, 0);
      check("reset_carry", o_carry, 0);
      check("reset_zero", o_zero, 0);
      check("reset_done", o_done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel16 = 1'(s);
      #1;
      check("post_reset_ready", o_ready, 1);
      check("post_reset_dout", o_dout, 0);
    end

    for (int s = 0; s < 2; s++) begin
      sel16 = 1'(s);
      run_suite();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_alu_core.md
REG_ALU_CORE -- requirements
Module: reg_alu_core

Interface
REQ-001 Parameter WIDTH, default 8, datapath and register width in bits (legal values 2 to 32).
REQ-002 Parameter DEPTH, default 8, number of general registers (power of 2, 2 to 16).
REQ-003 Derived constant AW = clog2(DEPTH), register address width; it is not user-overridable.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered this cycle.
REQ-007 cmd_ready  out  1  core accepts commands; 1 only in IDLE.
REQ-008 cmd_load  in  1  1 = load data_in into R[cmd_addr]; 0 = execute cmd_op.
REQ-009 cmd_addr  in  AW  load target, or B-operand select for execute.
REQ-010 cmd_op  in  4  operation code (REQ-016).
REQ-011 data_in  in  WIDTH  load data.
REQ-012 cin  in  1  carry input, sampled at accept.
REQ-013 data_out  out  WIDTH  continuous copy of R0.
REQ-014 carry  out  1  carry/borrow flag, registered.
REQ-015 zero  out  1  zero flag, registered; done  out  1  one-cycle pulse at execute completion.

Function
REQ-016 Opcodes: A = R0 and B = R[cmd_addr], both latched at accept; 0 ADD A+B; 1 ADC A+B+cin; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 MOV (result B); 7 NOT A; 8 MUL unsigned A*B; 9-15 reserved.
REQ-017 A command is accepted only on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_valid while cmd_ready=0 has no effect and is not queued.
REQ-018 An accepted load writes R[cmd_addr] on the accept edge, stays in IDLE, raises no done pulse and leaves the flags unchanged.
REQ-019 The FSM has states IDLE, EXEC and MUL; an accepted execute moves IDLE->EXEC, latching A, B, op and cin.
REQ-020 In EXEC, ops 0-7 and 9-15 return to IDLE on the next edge; on that edge ops 0-7 write R0 and the flags, and done=1 for the following cycle.
REQ-021 Single-cycle result latency: the result appears on data_out 2 edges after the accept edge, and cmd_ready returns to 1 in the same cycle.
REQ-022 Op 8: EXEC->MUL, then a shift-add loop with a counter running WIDTH iterations, one per cycle; after the last iteration go to IDLE, write the low WIDTH bits to R0 and the high WIDTH bits to R1, and pulse done; MUL latency is WIDTH+2 edges from accept.
REQ-023 Arithmetic is modulo 2^WIDTH. ADD and ADC set carry to the carry-out of bit WIDTH-1. SUB sets carry=1 iff A<B (unsigned borrow).
REQ-024 Ops 3-7 clear carry. MUL sets carry=1 iff the high half is nonzero.
REQ-025 zero=1 iff the value written to R0 is 0; for MUL, zero=1 iff the full 2*WIDTH-bit product is 0.
REQ-026 Reserved ops 9-15 write nothing and leave the flags unchanged, but still pulse done (a NOP).
REQ-027 B equal to R0 (cmd_addr=0) is legal: both operands take the latched R0 value.
REQ-028 A MUL with cmd_addr=1 uses the R1 value latched at accept, even though R1 is overwritten at completion.

Reset
REQ-029 While rst=1: every register R0..R[DEPTH-1] = 0, state = IDLE, counter = 0, carry = 0, zero = 0, done = 0.
REQ-030 In the cycle after reset release, cmd_ready=1 and data_out=0.
REQ-031 Reset asserted during EXEC or MUL aborts the operation: no register write, no done pulse, outputs are forced to their reset values immediately.

Verification
REQ-032 WIDTH=8: load R0=0xF0, load R3=0x20, then ADD addr 3 -> 2 edges later data_out=0x10, carry=1, zero=0, done=1 for one cycle.
REQ-033 R0=0x05, R2=0x07, SUB addr 2 -> data_out=0xFE, carry=1; then R2=0xFE, SUB addr 2 -> data_out=0x00, zero=1, carry=0.
REQ-034 R0=0xFF, R5=0xFF, MUL addr 5 -> cmd_ready=0 for WIDTH+1 cycles, then R0=0x01, R1=0xFE, carry=1, done=1.
REQ-035 cmd_valid held high with a load during MUL -> the load is ignored until cmd_ready=1, then accepted exactly once.
REQ-036 Assert rst mid-MUL -> all outputs 0 asynchronously, no done pulse; op 12 after reset -> done=1 with R0 and flags unchanged.
REQ-037 Re-run REQ-032 to REQ-034 with WIDTH=16, DEPTH=4, using scaled operands, and check that the MUL latency is 18 edges.
